// File: rtl/tri_pwm_deadtime.sv
// Centre-aligned complementary PWM with dead-time insertion.
// Duty setpoint is double-buffered and applied at the triangle valley.
module tri_pwm_deadtime #(
  parameter int CNT_W       = 4,
  parameter int DEAD_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_wr,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             period_start,
  output logic             duty_ack,
  output logic [CNT_W-1:0] duty_active
);

  localparam int DW = 4;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    H_ON,
    L_ON,
    DEAD
  } state_t;

  state_t           state, state_d;
  logic [DW-1:0]    dead_cnt, dead_d;
  logic [CNT_W-1:0] cnt_prev;
  logic [CNT_W-1:0] pending;
  logic             pending_valid;
  logic             raw_q;
  logic             valley;

  assign valley = (cnt == '0) && (cnt_prev != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_prev      <= '1;
      pending       <= '0;
      pending_valid <= 1'b0;
      duty_active   <= '0;
      period_start  <= 1'b0;
      duty_ack      <= 1'b0;
      raw_q         <= 1'b0;
    end else begin
      cnt_prev     <= cnt;
      period_start <= valley;
      duty_ack     <= valley && pending_valid;
      raw_q        <= enable && (cnt < duty_active);
      if (valley && pending_valid) begin
        duty_active   <= pending;
        pending_valid <= 1'b0;
      end
      // A write on the valley cycle is held for the next period
      if (duty_wr) begin
        pending       <= duty_in;
        pending_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    dead_d  = dead_cnt;
    if (!enable) begin
      state_d = IDLE;
      dead_d  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = DEAD;
          dead_d  = '0;
        end
        H_ON: begin
          if (!raw_q) begin
            state_d = DEAD;
            dead_d  = '0;
          end
        end
        L_ON: begin
          if (raw_q) begin
            state_d = DEAD;
            dead_d  = '0;
          end
        end
        DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            state_d = raw_q ? H_ON : L_ON;
            dead_d  = '0;
          end else begin
            dead_d = dead_cnt + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          dead_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dead_cnt <= '0;
      pwm_h    <= 1'b0;
      pwm_l    <= 1'b0;
    end else begin
      state    <= state_d;
      dead_cnt <= dead_d;
      pwm_h    <= (state_d == H_ON);
      pwm_l    <= (state_d == L_ON);
    end
  end

endmodule

// File: tb/tb_tri_pwm_deadtime.sv
// Bench for tri_pwm_deadtime: duty table, corner sequences and
// randomized run against a behavioural model.
module tb_tri_pwm_deadtime;

  localparam int DEAD = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] cnt;
  logic [3:0] duty_in;
  logic       duty_wr;
  logic       pwm_h;
  logic       pwm_l;
  logic       period_start;
  logic       duty_ack;
  logic [3:0] duty_active;

  always #5 clock = ~clock;

  tri_pwm_deadtime #(.CNT_W(4), .DEAD_CYCLES(DEAD)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .cnt(cnt),
    .duty_in(duty_in),
    .duty_wr(duty_wr),
    .pwm_h(pwm_h),
    .pwm_l(pwm_l),
    .period_start(period_start),
    .duty_ack(duty_ack),
    .duty_active(duty_active)
  );

  int checks = 0;
  int errors = 0;
  int p = 0;
  int n_h, n_l, n_low;

  // behavioural model: mode 0 off, 1 dead window, 2 driving
  int m_prev, m_pend, m_pv, m_duty, m_ps, m_ack, m_raw;
  int m_mode, m_left, m_side;

  typedef struct {
    int duty;
    int exp_h;
    int exp_l;
    int exp_low;
  } vec_t;

  vec_t tbl[4];

  function automatic int tri_val(int i);
    return (i < 16) ? i : 31 - i;
  endfunction

  task automatic model_reset();
    m_prev = 15; m_pend = 0; m_pv = 0; m_duty = 0;
    m_ps = 0; m_ack = 0; m_raw = 0;
    m_mode = 0; m_left = 0; m_side = 0;
  endtask

  task automatic model_edge();
    int c;
    bit v;
    int n_raw;
    c = int'(cnt);
    v = (c == 0) && (m_prev != 0);
    n_raw = (enable && (c < m_duty)) ? 1 : 0;
    if (!enable) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_left = DEAD;
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_mode = 2;
        m_side = (m_raw != 0) ? 1 : 2;
      end
    end else if ((m_side == 1) != (m_raw != 0)) begin
      m_mode = 1; m_left = DEAD;
    end
    m_ps  = v ? 1 : 0;
    m_ack = (v && m_pv != 0) ? 1 : 0;
    if (v && m_pv != 0) begin
      m_duty = m_pend; m_pv = 0;
    end
    if (duty_wr) begin
      m_pend = int'(duty_in); m_pv = 1;
    end
    m_raw  = n_raw;
    m_prev = c;
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    int eh, el;
    model_edge();
    @(posedge clock);
    #1;
    eh = (m_mode == 2 && m_side == 1) ? 1 : 0;
    el = (m_mode == 2 && m_side == 2) ? 1 : 0;
    checks++;
    if (pwm_h !== 1'(eh) || pwm_l !== 1'(el) ||
        period_start !== 1'(m_ps) || duty_ack !== 1'(m_ack) ||
        duty_active !== 4'(m_duty)) begin
      errors++;
      $display("FAIL model t=%0t: h/l/ps/ack/duty got %b%b%b%b/%0d expected %0d%0d%0d%0d/%0d",
               $time, pwm_h, pwm_l, period_start, duty_ack, duty_active,
               eh, el, m_ps, m_ack, m_duty);
    end
    checks++;
    if (pwm_h && pwm_l) begin
      errors++;
      $display("FAIL overlap t=%0t: got h=1 l=1 expected not both", $time);
    end
    n_h   += int'(pwm_h);
    n_l   += int'(pwm_l);
    n_low += int'(!pwm_h && !pwm_l);
    p = (p + 1) % 32;
    cnt = 4'(tri_val(p));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_outputs",
          int'({pwm_h, pwm_l, period_start, duty_ack}), 0);
    check("reset_duty_active", int'(duty_active), 0);
    p = 0;
    cnt = 4'd0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic write_duty(int d);
    duty_in = 4'(d);
    duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic to_valley(string name);
    int k;
    k = 0;
    while (!(cnt == 4'd0 && m_prev != 0) && k < 64) begin
      step();
      k++;
    end
    if (k >= 64) check({name, "_timeout"}, k, 0);
  endtask

  task automatic wait_mode(string name, int mode, int side);
    int k;
    k = 0;
    while (!(m_mode == mode && (side == 0 || m_side == side)) && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) check({name, "_timeout"}, k, 0);
  endtask

  initial begin
    tbl[0] = '{duty: 8,  exp_h: 14, exp_l: 14, exp_low: 4};
    tbl[1] = '{duty: 0,  exp_h: 0,  exp_l: 32, exp_low: 0};
    tbl[2] = '{duty: 15, exp_h: 30, exp_l: 0,  exp_low: 2};
    tbl[3] = '{duty: 1,  exp_h: 0,  exp_l: 30, exp_low: 2};

    reset   = 1'b1;
    enable  = 1'b0;
    duty_wr = 1'b0;
    duty_in = 4'd0;
    cnt     = 4'd0;
    repeat (2) @(negedge clock);
    do_reset();
    enable = 1'b1;

    foreach (tbl[i]) begin
      write_duty(tbl[i].duty);
      run(96);
      n_h = 0; n_l = 0; n_low = 0;
      run(32);
      check($sformatf("duty%0d_h", tbl[i].duty), n_h, tbl[i].exp_h);
      check($sformatf("duty%0d_l", tbl[i].duty), n_l, tbl[i].exp_l);
      check($sformatf("duty%0d_low", tbl[i].duty), n_low, tbl[i].exp_low);
    end

    // double buffering: last write wins, valley-cycle write deferred
    while (p != 10) step();
    write_duty(5);
    run(3);
    write_duty(9);
    to_valley("buf1");
    write_duty(3);
    check("buf_apply9_duty", int'(duty_active), 9);
    check("buf_apply9_ack", int'(duty_ack), 1);
    step();
    check("buf_ack_pulse", int'(duty_ack), 0);
    to_valley("buf2");
    step();
    check("buf_apply3_duty", int'(duty_active), 3);
    check("buf_apply3_ack", int'(duty_ack), 1);

    // enable drop while high side is on, then re-enable
    write_duty(8);
    wait_mode("en_h", 2, 1);
    enable = 1'b0;
    step();
    check("dis_outputs", int'({pwm_h, pwm_l}), 0);
    run(3);
    check("dis_hold", int'({pwm_h, pwm_l}), 0);
    enable = 1'b1;
    step();
    check("reen_dead1", int'({pwm_h, pwm_l}), 0);
    step();
    check("reen_dead2", int'({pwm_h, pwm_l}), 0);
    step();
    check("reen_on", int'(pwm_h | pwm_l), 1);

    // asynchronous reset mid dead-time and mid high-side
    wait_mode("rst_dead", 1, 0);
    do_reset();
    write_duty(8);
    wait_mode("rst_h", 2, 1);
    check("pre_rst_h", int'(pwm_h), 1);
    do_reset();

    // randomized run
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      duty_wr = ($urandom_range(0, 9) == 0);
      duty_in = 4'($urandom_range(0, 15));
      step();
    end
    duty_wr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
